// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer.
//   OPC_JUMP / OPC_HALT : opcodes decoded from instr[31:28]
//   state_t             : sequencer state encoding (3 bits, all codes used)
//   opcode_of()         : extracts the opcode field from an instruction word
package cpu_pkg;

    localparam logic [3:0] OPC_JUMP = 4'hF;
    localparam logic [3:0] OPC_HALT = 4'hE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        JUMP   = 3'd5,
        HALT   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    function automatic logic [3:0] opcode_of(input logic [31:0] instr);
        return instr[31:28];
    endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// Saturating up-counter used to bound the FETCH wait for program memory.
//   i_clk   : system clock
//   i_rst_n : async active-low reset (count -> 0)
//   i_clear : synchronous clear, wins over i_en
//   i_en    : count enable; the count stops at TC
//   o_tc    : 1 while the count equals TC
module cpu_wait_timer #(
    parameter int TC = 15,
    parameter int W  = $clog2(TC + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [W-1:0] TC_V = W'(TC);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != TC_V)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == TC_V);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the single-issue datapath.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_start                   : level; leaves IDLE when 1
//   i_instr, i_mem_ready      : program-memory read data and its valid
//   i_zero_in, i_neg_in       : ALU flags, latched during WB
//   o_mem_read, o_ir_load     : memory request / instruction capture strobe
//   o_ir, o_alu_op            : registered instruction and ALU opcode
//   o_pc_enable, o_pc_sel     : PC update strobe, 0 = PC+4, 1 = ir[27:0]
//   o_flag_we, o_zero_flag, o_neg_flag : flag update strobe and latched flags
//   o_busy, o_halted, o_error : status
//   o_retired                 : completed-instruction count (wraps)
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | memory read outstanding, timeout running
// DECODE | classify ir opcode
// EXEC   | ALU settles on registered alu_op
// WB     | latch flags, advance PC by 4, retire
// JUMP   | load PC from jump target, retire
// HALT   | stopped by HALT opcode until reset
// ERROR  | memory timeout, stopped until reset
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [31:0]         i_instr,
    input  logic                i_mem_ready,
    input  logic                i_zero_in,
    input  logic                i_neg_in,
    output logic                o_mem_read,
    output logic                o_ir_load,
    output logic [31:0]         o_ir,
    output logic [3:0]          o_alu_op,
    output logic                o_pc_enable,
    output logic                o_pc_sel,
    output logic                o_flag_we,
    output logic                o_zero_flag,
    output logic                o_neg_flag,
    output logic                o_busy,
    output logic                o_halted,
    output logic                o_error,
    output logic [RETIRE_W-1:0] o_retired
);

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_ir;
    logic [3:0]            r_alu_op;
    logic                  r_zero;
    logic                  r_neg;
    logic [RETIRE_W-1:0]   r_retired;
    logic                  w_in_fetch;
    logic                  w_tmr_tc;
    logic [3:0]            w_op;

    assign w_in_fetch = (r_state == FETCH);
    assign w_op       = opcode_of(r_ir);

    // Counter sits at 0 outside FETCH; its terminal count marks the last
    // cycle FETCH may wait before giving up.
    cpu_wait_timer #(
        .TC (MEM_TIMEOUT - 1)
    ) u_wait_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (!w_in_fetch || i_mem_ready),
        .i_en    (w_in_fetch),
        .o_tc    (w_tmr_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_mem_read  = 1'b0;
        o_ir_load   = 1'b0;
        o_pc_enable = 1'b0;
        o_pc_sel    = 1'b0;
        o_flag_we   = 1'b0;
        o_busy      = 1'b1;
        o_halted    = 1'b0;
        o_error     = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = FETCH;
            end
            FETCH: begin
                o_mem_read = 1'b1;
                // Capture strobe coincides with the ready cycle so the IR
                // loads in the same edge that leaves FETCH.
                o_ir_load  = i_mem_ready;
                // Ready on the final count cycle still wins over timeout.
                if (i_mem_ready)   w_next = DECODE;
                else if (w_tmr_tc) w_next = ERROR;
            end
            DECODE: begin
                if (w_op == OPC_HALT)      w_next = HALT;
                else if (w_op == OPC_JUMP) w_next = JUMP;
                else                       w_next = EXEC;
            end
            EXEC: begin
                w_next = WB;
            end
            WB: begin
                o_flag_we   = 1'b1;
                o_pc_enable = 1'b1;
                w_next      = FETCH;
            end
            JUMP: begin
                o_pc_enable = 1'b1;
                o_pc_sel    = 1'b1;
                w_next      = FETCH;
            end
            HALT: begin
                o_busy   = 1'b0;
                o_halted = 1'b1;
            end
            ERROR: begin
                o_busy  = 1'b0;
                o_error = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ir      <= '0;
            r_alu_op  <= '0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_in_fetch && i_mem_ready) begin
                r_ir <= i_instr;
            end
            if ((r_state == DECODE) && (w_op != OPC_HALT) && (w_op != OPC_JUMP)) begin
                r_alu_op <= w_op;
            end
            if (r_state == WB) begin
                r_zero <= i_zero_in;
                r_neg  <= i_neg_in;
            end
            if ((r_state == WB) || (r_state == JUMP)) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign o_ir        = r_ir;
    assign o_alu_op    = r_alu_op;
    assign o_zero_flag = r_zero;
    assign o_neg_flag  = r_neg;
    assign o_retired   = r_retired;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl. A transaction-level model predicts,
// per instruction, its length, the strobe counts and positions, and the
// architectural registers left behind.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero_in;
    logic        neg_in;
    logic        o_mem_read, o_ir_load, o_pc_enable, o_pc_sel, o_flag_we;
    logic        o_zero_flag, o_neg_flag, o_busy, o_halted, o_error;
    logic [31:0] o_ir;
    logic [3:0]  o_alu_op;
    logic [15:0] o_retired;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_ir;
    logic [3:0]  m_alu;
    logic        m_zero, m_neg;
    logic [15:0] m_ret;

    cpu_seq_ctrl #(.MEM_TIMEOUT(16), .RETIRE_W(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_instr     (instr),
        .i_mem_ready (mem_ready),
        .i_zero_in   (zero_in),
        .i_neg_in    (neg_in),
        .o_mem_read  (o_mem_read),
        .o_ir_load   (o_ir_load),
        .o_ir        (o_ir),
        .o_alu_op    (o_alu_op),
        .o_pc_enable (o_pc_enable),
        .o_pc_sel    (o_pc_sel),
        .o_flag_we   (o_flag_we),
        .o_zero_flag (o_zero_flag),
        .o_neg_flag  (o_neg_flag),
        .o_busy      (o_busy),
        .o_halted    (o_halted),
        .o_error     (o_error),
        .o_retired   (o_retired)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ir = '0; m_alu = '0; m_zero = 1'b0; m_neg = 1'b0; m_ret = '0;
    endtask

    // Inputs change on the falling edge; outputs are observed 1 time unit later.
    task automatic tick(input logic rdy, input logic [31:0] ins, input logic z, input logic n);
        @(negedge clk);
        mem_ready = rdy; instr = ins; zero_in = z; neg_in = n;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Runs one non-HALT instruction starting in its first FETCH cycle.
    task automatic run_instr(input logic [31:0] ins, input int waits);
        logic is_jump;
        int   len, n_rd, n_ld, ld_at, n_pe, pe_at, n_fw, fw_at, not_busy;
        logic pe_sel, r, z, n, zexp, nexp;
        is_jump = (ins[31:28] == 4'hF);
        len = waits + 1 + (is_jump ? 2 : 3);
        n_rd = 0; n_ld = 0; ld_at = -1; n_pe = 0; pe_at = -1; n_fw = 0; fw_at = -1;
        not_busy = 0; pe_sel = 1'b0; zexp = 1'b0; nexp = 1'b0;
        for (int c = 0; c < len; c++) begin
            z = 1'($urandom); n = 1'($urandom);
            r = (c < waits) ? 1'b0 : (c == waits) ? 1'b1 : 1'($urandom);
            tick(r, (c == waits) ? ins : $urandom, z, n);
            if (o_mem_read) n_rd++;
            if (o_ir_load) begin n_ld++; ld_at = c; end
            if (o_pc_enable) begin n_pe++; pe_at = c; pe_sel = o_pc_sel; end
            if (o_flag_we) begin n_fw++; fw_at = c; end
            if (!o_busy) not_busy++;
            if (c == len - 1) begin zexp = z; nexp = n; end
        end
        m_ir = ins;
        m_ret = m_ret + 16'd1;
        if (!is_jump) begin
            m_alu = ins[31:28]; m_zero = zexp; m_neg = nexp;
        end
        @(posedge clk); #1;
        total++; if (n_rd !== waits + 1) begin bad++; $display("FAIL mem_read_cycles: got %0d want %0d", n_rd, waits + 1); end
        total++; if (n_ld !== 1 || ld_at !== waits) begin bad++; $display("FAIL ir_load: count %0d at %0d want 1 at %0d", n_ld, ld_at, waits); end
        total++; if (n_pe !== 1 || pe_at !== len - 1) begin bad++; $display("FAIL pc_enable: count %0d at %0d want 1 at %0d", n_pe, pe_at, len - 1); end
        total++; if (pe_sel !== is_jump) begin bad++; $display("FAIL pc_sel: got %0b want %0b", pe_sel, is_jump); end
        total++; if (n_fw !== (is_jump ? 0 : 1) || (!is_jump && fw_at !== len - 1)) begin bad++; $display("FAIL flag_we: count %0d at %0d jump=%0b", n_fw, fw_at, is_jump); end
        total++; if (not_busy !== 0) begin bad++; $display("FAIL busy: %0d idle cycles, want 0", not_busy); end
        total++; if (o_ir !== m_ir) begin bad++; $display("FAIL ir: got %h want %h", o_ir, m_ir); end
        total++; if (o_alu_op !== m_alu) begin bad++; $display("FAIL alu_op: got %h want %h", o_alu_op, m_alu); end
        total++; if (o_retired !== m_ret) begin bad++; $display("FAIL retired: got %0d want %0d", o_retired, m_ret); end
        total++; if ({o_zero_flag, o_neg_flag} !== {m_zero, m_neg}) begin bad++; $display("FAIL flags: got %b want %b", {o_zero_flag, o_neg_flag}, {m_zero, m_neg}); end
    endtask

    task automatic run_halt(input int waits);
        logic [31:0] ins;
        int strobes, stray;
        ins = 32'hE000_0000 | ($urandom & 32'h0FFF_FFFF);
        strobes = 0; stray = 0;
        for (int c = 0; c < waits + 2; c++) begin
            tick((c == waits), (c == waits) ? ins : $urandom, 1'($urandom), 1'($urandom));
            if (o_pc_enable || o_flag_we) strobes++;
        end
        @(posedge clk); #1;
        total++; if (o_halted !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL halt_state: halted %b busy %b want 1 0", o_halted, o_busy); end
        total++; if (strobes !== 0) begin bad++; $display("FAIL halt_strobes: got %0d want 0", strobes); end
        total++; if (o_retired !== m_ret || o_alu_op !== m_alu) begin bad++; $display("FAIL halt_regs: retired %0d alu %h want %0d %h", o_retired, o_alu_op, m_ret, m_alu); end
        for (int c = 0; c < 5; c++) begin
            start = 1'($urandom);
            tick(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            if (!o_halted || o_mem_read || o_ir_load || o_pc_enable || o_flag_we || o_busy) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL halt_terminal: %0d bad cycles want 0", stray); end
    endtask

    task automatic test_reset();
        int act;
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; instr = '0; zero_in = 1'b0; neg_in = 1'b0;
        #3;
        model_reset();
        total++; if ({o_mem_read, o_ir_load, o_pc_enable, o_pc_sel, o_flag_we, o_zero_flag, o_neg_flag, o_busy, o_halted, o_error} !== 10'b0)
            begin bad++; $display("FAIL reset_strobes: got nonzero want 0"); end
        total++; if (o_ir !== 32'h0 || o_alu_op !== 4'h0 || o_retired !== 16'h0)
            begin bad++; $display("FAIL reset_regs: ir %h alu %h ret %0d want 0", o_ir, o_alu_op, o_retired); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        for (int c = 0; c < 4; c++) begin
            tick(1'b1, $urandom, 1'b1, 1'b1);
            if (o_busy || o_mem_read) act++;
        end
        total++; if (act !== 0) begin bad++; $display("FAIL idle_hold: %0d active cycles want 0", act); end
    endtask

    task automatic test_alu_halt();
        do_reset();
        start = 1'b1;
        run_instr(32'h1000_0005, 0);
        run_halt(0);
    endtask

    task automatic test_jump();
        do_reset();
        start = 1'b1;
        run_instr(32'h1000_0005, 0);
        run_instr(32'hF000_0040, 0);
        run_instr(32'h2000_0007, 0);
    endtask

    task automatic test_wait();
        do_reset();
        start = 1'b1;
        run_instr(32'h3000_0001, 3);
        run_instr(32'h4000_0002, 15);
        run_instr(32'hF000_0100, 15);
    endtask

    task automatic test_timeout();
        int n_rd, n_err, stray;
        do_reset();
        start = 1'b1;
        n_rd = 0; n_err = 0; stray = 0;
        for (int c = 0; c < 16; c++) begin
            tick(1'b0, $urandom, 1'($urandom), 1'($urandom));
            if (o_mem_read) n_rd++;
            if (o_error) n_err++;
        end
        @(posedge clk); #1;
        total++; if (n_rd !== 16 || n_err !== 0) begin bad++; $display("FAIL timeout_fetch: mem_read %0d error %0d want 16 0", n_rd, n_err); end
        total++; if (o_error !== 1'b1 || o_busy !== 1'b0 || o_mem_read !== 1'b0) begin bad++; $display("FAIL timeout_error: err %b busy %b rd %b want 1 0 0", o_error, o_busy, o_mem_read); end
        for (int c = 0; c < 5; c++) begin
            start = 1'($urandom);
            tick(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            if (!o_error || o_mem_read || o_ir_load || o_pc_enable || o_flag_we || o_busy || o_halted) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL error_terminal: %0d bad cycles want 0", stray); end
    endtask

    task automatic test_reset_mid_exec();
        int pulses;
        do_reset();
        start = 1'b1;
        tick(1'b1, 32'h2000_0003, 1'b0, 1'b0);
        tick(1'b0, $urandom, 1'b0, 1'b0);
        tick(1'b0, $urandom, 1'b1, 1'b1);
        total++; if (o_alu_op !== 4'h2 || o_busy !== 1'b1) begin bad++; $display("FAIL exec_before_reset: alu %h busy %b want 2 1", o_alu_op, o_busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({o_mem_read, o_ir_load, o_pc_enable, o_pc_sel, o_flag_we, o_busy, o_halted, o_error} !== 8'b0 || o_ir !== 32'h0 || o_alu_op !== 4'h0)
            begin bad++; $display("FAIL async_reset: ir %h alu %h busy %b want 0", o_ir, o_alu_op, o_busy); end
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (o_pc_enable || o_busy || o_retired !== 16'h0) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL reset_hold: %0d bad cycles want 0", pulses); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        start = 1'b1;
        run_instr(32'h5000_0009, 1);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int waits;
        do_reset();
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            ins = $urandom;
            if (ins[31:28] == 4'hE) ins[31:28] = 4'h0;
            waits = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            run_instr(ins, waits);
            start = 1'b0;
        end
        run_halt(int'($urandom_range(0, 2)));
    endtask

    initial begin
        test_reset();
        test_alu_halt();
        test_jump();
        test_wait();
        test_timeout();
        test_reset_mid_exec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
